// File: rtl/alarm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_seq_ctrl
// Brief    : Alarm clock sequencer (idle / ringing / snoozing) with BCD snooze
//            target arithmetic and registered display mux.
// Revision : 1.0
// ============================================================================
module alarm_seq_ctrl #(
    parameter int SNOOZE_MIN   = 5,
    parameter int MAX_SNOOZE   = 3,
    parameter int RING_TIMEOUT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        one_minute,
    input  logic [15:0] current_time,
    input  logic [15:0] alarm_time,
    input  logic        alarm_enable,
    input  logic        snooze_btn,
    input  logic        stop_btn,
    input  logic        show_alarm,
    output logic [15:0] display,
    output logic        sound_alarm,
    output logic        snooze_active,
    output logic [1:0]  snooze_count,
    output logic [15:0] target_time
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RINGING  = 2'd1,
        S_SNOOZING = 2'd2
    } state_t;

    localparam logic [3:0] c_snz_tens     = 4'(SNOOZE_MIN / 10);
    localparam logic [3:0] c_snz_units    = 4'(SNOOZE_MIN % 10);
    localparam logic [1:0] c_max_snooze   = 2'(MAX_SNOOZE);
    localparam logic [3:0] c_ring_timeout = 4'(RING_TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_snooze_prev;
    logic        r_stop_prev;
    logic        r_btn_armed;
    logic [3:0]  r_ring_cnt;
    logic [3:0]  w_ring_nxt;
    logic [3:0]  w_ring_inc;
    logic [1:0]  w_count_nxt;
    logic        w_load_target;
    logic        w_snooze_edge;
    logic        w_stop_edge;
    logic        w_alarm_match;
    logic        w_target_match;

    logic [4:0]  w_u_sum;
    logic        w_u_carry;
    logic [3:0]  w_new_mu;
    logic [4:0]  w_t_sum;
    logic        w_h_carry;
    logic [3:0]  w_new_mt;
    logic        w_hu_wrap;
    logic [3:0]  w_new_hu;
    logic [3:0]  w_new_ht;
    logic [15:0] w_snooze_target;

    // Edges are masked on the first cycle after reset so a held button stays silent.
    assign w_snooze_edge  = snooze_btn & ~r_snooze_prev & r_btn_armed;
    assign w_stop_edge    = stop_btn & ~r_stop_prev & r_btn_armed;
    assign w_alarm_match  = (current_time == alarm_time);
    assign w_target_match = (current_time == target_time);
    assign w_ring_inc     = r_ring_cnt + 4'd1;

    // Digit-wise BCD add; the +6/+10 corrections are the mod-16 forms of -10/-6.
    always_comb begin
        w_u_sum   = {1'b0, current_time[3:0]} + {1'b0, c_snz_units};
        w_u_carry = (w_u_sum >= 5'd10);
        w_new_mu  = w_u_sum[3:0] + (w_u_carry ? 4'd6 : 4'd0);
        w_t_sum   = {1'b0, current_time[7:4]} + {1'b0, c_snz_tens} + {4'd0, w_u_carry};
        w_h_carry = (w_t_sum >= 5'd6);
        w_new_mt  = w_t_sum[3:0] + (w_h_carry ? 4'd10 : 4'd0);
        w_hu_wrap = w_h_carry && (current_time[11:8] == 4'd9);
        w_new_hu  = w_hu_wrap ? 4'd0 : (current_time[11:8] + {3'd0, w_h_carry});
        w_new_ht  = current_time[15:12] + {3'd0, w_hu_wrap};
        if ({w_new_ht, w_new_hu} == 8'h24) begin
            w_snooze_target = {8'h00, w_new_mt, w_new_mu};
        end else begin
            w_snooze_target = {w_new_ht, w_new_hu, w_new_mt, w_new_mu};
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ring_nxt    = r_ring_cnt;
        w_count_nxt   = snooze_count;
        w_load_target = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_count_nxt = 2'd0;
                if (!w_stop_edge && alarm_enable && one_minute && w_alarm_match) begin
                    w_state_nxt = S_RINGING;
                    w_ring_nxt  = 4'd0;
                end
            end
            S_RINGING: begin
                if (w_stop_edge || !alarm_enable) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = 2'd0;
                    w_ring_nxt  = 4'd0;
                end else if (w_snooze_edge && (snooze_count < c_max_snooze)) begin
                    w_state_nxt   = S_SNOOZING;
                    w_count_nxt   = snooze_count + 2'd1;
                    w_load_target = 1'b1;
                end else if (one_minute) begin
                    w_ring_nxt = w_ring_inc;
                    if (w_ring_inc == c_ring_timeout) begin
                        w_state_nxt = S_IDLE;
                        w_count_nxt = 2'd0;
                        w_ring_nxt  = 4'd0;
                    end
                end
            end
            S_SNOOZING: begin
                if (w_stop_edge || !alarm_enable) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = 2'd0;
                end else if (one_minute && w_target_match) begin
                    w_state_nxt = S_RINGING;
                    w_ring_nxt  = 4'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = 2'd0;
                w_ring_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ring_cnt    <= 4'd0;
            r_snooze_prev <= 1'b0;
            r_stop_prev   <= 1'b0;
            r_btn_armed   <= 1'b0;
            snooze_count  <= 2'd0;
            sound_alarm   <= 1'b0;
            snooze_active <= 1'b0;
            target_time   <= 16'h0000;
            display       <= 16'h0000;
        end else begin
            r_state       <= w_state_nxt;
            r_ring_cnt    <= w_ring_nxt;
            r_snooze_prev <= snooze_btn;
            r_stop_prev   <= stop_btn;
            r_btn_armed   <= 1'b1;
            snooze_count  <= w_count_nxt;
            sound_alarm   <= (w_state_nxt == S_RINGING);
            snooze_active <= (w_state_nxt == S_SNOOZING);
            if (w_load_target) begin
                target_time <= w_snooze_target;
            end else if (w_state_nxt != S_SNOOZING) begin
                target_time <= alarm_time;
            end
            display <= show_alarm ? target_time : current_time;
        end
    end

endmodule
`default_nettype wire

// File: doc/alarm_seq_ctrl.md
ALARM_SEQ_CTRL -- requirements
Module: alarm_seq_ctrl

Interface
REQ-001 Parameter SNOOZE_MIN, default 5, minutes added per snooze; legal range 1..59.
REQ-002 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event; legal range 1..3.
REQ-003 Parameter RING_TIMEOUT, default 10, one_minute pulses of continuous ringing before auto-off; legal range 1..15.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 one_minute  in  1  single-cycle pulse, one per minute, synchronous to clk.
REQ-007 current_time  in  16  BCD HH:MM, 24-hour, [15:12]=H tens, [11:8]=H units, [7:4]=M tens, [3:0]=M units.
REQ-008 alarm_time  in  16  BCD HH:MM, same format.
REQ-009 alarm_enable  in  1  level; low disarms the alarm.
REQ-010 snooze_btn  in  1  level, synchronous; action on rising edge only.
REQ-011 stop_btn  in  1  level, synchronous; action on rising edge only.
REQ-012 show_alarm  in  1  level; selects display source.
REQ-013 display  out  16  registered BCD time for the display.
REQ-014 sound_alarm  out  1  registered; high while ringing.
REQ-015 snooze_active  out  1  registered; high while in SNOOZING.
REQ-016 snooze_count  out  2  registered; snoozes used in the current alarm event.
REQ-017 target_time  out  16  registered; active wake time (snooze target in SNOOZING, else alarm_time copy).

Function
REQ-018 FSM states IDLE, RINGING, SNOOZING; state register and all outputs are flops.
REQ-019 Edge detect: btn_prev flops; edge = btn & ~btn_prev; a held button produces one edge.
REQ-020 Per-cycle event priority: stop edge > alarm_enable low > snooze edge > one_minute.
REQ-021 IDLE -> RINGING when one_minute & alarm_enable & (current_time == alarm_time); ring counter and snooze_count cleared.
REQ-022 RINGING -> IDLE on stop edge; snooze_count cleared.
REQ-023 RINGING -> SNOOZING on snooze edge when snooze_count < MAX_SNOOZE; target_time <= current_time + SNOOZE_MIN; snooze_count increments.
REQ-024 Snooze edge in RINGING with snooze_count == MAX_SNOOZE ignored; ringing continues.
REQ-025 In RINGING each one_minute not pre-empted by higher-priority event increments ring counter (4-bit); reaching RING_TIMEOUT -> IDLE, snooze_count cleared.
REQ-026 SNOOZING -> RINGING when one_minute & (current_time == target_time); ring counter cleared, snooze_count kept.
REQ-027 SNOOZING -> IDLE on stop edge; snooze edge in SNOOZING ignored.
REQ-028 alarm_enable low in any state -> IDLE next edge; snooze_count cleared.
REQ-029 BCD add: minutes += SNOOZE_MIN; minutes >= 60 -> minutes -= 60, hours += 1; hours == 24 -> 00; result always valid BCD.
REQ-030 sound_alarm = 1 exactly when state is RINGING; asserts the cycle after the triggering one_minute pulse (latency 1).
REQ-031 snooze_active = 1 exactly when state is SNOOZING.
REQ-032 target_time tracks alarm_time every cycle outside SNOOZING; holds the snooze target in SNOOZING.
REQ-033 display <= show_alarm ? target_time : current_time, registered, latency 1 cycle.
REQ-034 Non-BCD current_time or alarm_time: outputs stay 0/1 (no X); state behaviour unspecified.

Reset
REQ-035 rst_n low: immediately state IDLE, display 16'h0000, sound_alarm 0, snooze_active 0, snooze_count 0, target_time 16'h0000, ring counter 0, btn_prev 0.
REQ-036 Reset mid-RINGING or mid-SNOOZING discards the event; after release, only a new alarm_time match rings.
REQ-037 Button held high across reset release produces no edge until released and pressed again.

Verification
REQ-038 alarm_time 0730, enable 1, current_time 0730, one_minute pulse -> sound_alarm 1 next cycle, snooze_count 0.
REQ-039 Ringing at 0758, snooze edge -> snooze_active 1, target_time 0803, snooze_count 1; one_minute at current_time 0803 -> sound_alarm 1.
REQ-040 Ringing at 2357, snooze edge -> target_time 0002; one_minute at 0002 -> ring.
REQ-041 Three snoozes used, ringing, fourth snooze edge -> state stays RINGING, snooze_count 3; stop edge -> IDLE, snooze_count 0.
REQ-042 Ringing, 10 one_minute pulses, no buttons -> sound_alarm 0 after 10th pulse; same-cycle stop and snooze edges -> IDLE.
REQ-043 rst_n low mid-RINGING -> sound_alarm 0 without a clock edge; show_alarm 1 with alarm_time 0615 -> display 0615 one cycle later.
